multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001: Parameter MEM_TIMEOUT, default 255, is the maximum number of cycles a memory request may wait for mem_ready before a trap is raised.
REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-005: branch_taken  input  1  comparator result for the current branch; sampled in EXEC only.
REQ-006: mem_ready  input  1  memory handshake; completes the outstanding request in the cycle it is high.
REQ-007: mem_req  output  1  memory request; held high until mem_ready.
REQ-008: mem_we  output  1  write qualifier for mem_req; meaningful only for stores.
REQ-009: ir_write  output  1  instruction register load strobe.
REQ-010: pc_write  output  1  PC update strobe; pulses exactly once per retired instruction.
REQ-011: pc_src  output  2  next-PC select: 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1.
REQ-012: imm_sel  output  3  immediate format select: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none.
REQ-013: alu_src_b  output  1  ALU operand B select: 0 = rs2, 1 = immediate.
REQ-014: reg_write  output  1  register file write strobe.
REQ-015: wb_sel  output  2  write-back select: 0 = ALU, 1 = memory data, 2 = pc+4, 3 = immediate.
REQ-016: trap  output  1  sticky fault flag.
REQ-017: state  output  3  current state encoding, for debug.

Function
REQ-018: States and encodings SHALL be FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5; unused codes SHALL transition to TRAP.
REQ-019: In FETCH, mem_req = 1 and mem_we = 0; when mem_ready = 1, ir_write = 1 for that cycle and the next state is DECODE, otherwise the FSM stays in FETCH.
REQ-020: DECODE SHALL last one cycle and latch opcode internally; later states use only the latched value.
REQ-021: Legal opcodes are 0110011 (R), 0010011 (OP-IMM), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL) and 1100111 (JALR); any other opcode SHALL cause DECODE -> TRAP.
REQ-022: imm_sel SHALL be driven from the latched opcode in DECODE, EXEC, MEM and WB as follows: R = 7, OP-IMM/LOAD/JALR = 0, STORE = 1, BRANCH = 2, LUI/AUIPC = 3, JAL = 4; it SHALL be 7 in FETCH and TRAP.
REQ-023: alu_src_b SHALL be 0 for R and BRANCH and 1 for all other legal opcodes.
REQ-024: From EXEC, BRANCH SHALL assert pc_write with pc_src = 1 if branch_taken and pc_src = 0 otherwise, then go to FETCH.
REQ-025: From EXEC, LOAD and STORE SHALL go to MEM; all remaining legal opcodes SHALL go to WB.
REQ-026: In MEM, mem_req = 1, and mem_we = 1 only for STORE; on mem_ready, LOAD SHALL go to WB, and STORE SHALL assert pc_write with pc_src = 0 and go to FETCH.
REQ-027: In WB, reg_write = 1 and pc_write = 1; wb_sel SHALL be LOAD = 1, JAL/JALR = 2, LUI = 3, otherwise 0; pc_src SHALL be JAL = 1, JALR = 2, otherwise 0; the next state is FETCH.
REQ-028: A wait counter (8 bits, saturating) SHALL clear on entry to FETCH and MEM and increment each cycle mem_req = 1 and mem_ready = 0; when it reaches MEM_TIMEOUT, the next state SHALL be TRAP.
REQ-029: If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win.
REQ-030: mem_ready while mem_req = 0 SHALL be ignored.
REQ-031: TRAP SHALL be absorbing until rst: trap = 1, and all strobes (mem_req, ir_write, pc_write, reg_write) and mem_we SHALL be 0.
REQ-032: Strobes SHALL be 0 in every state and condition not listed above; pc_write and reg_write SHALL never both pulse for the same instruction more than once.
REQ-033: Latency without memory wait states SHALL be: branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4 cycles, store 4 cycles, load 5 cycles.

Reset
REQ-034: A clock edge with rst = 1 SHALL set state to FETCH, clear the latched opcode, the wait counter and trap, from any state including mid-MEM.
REQ-035: While rst = 1, all strobe outputs SHALL be 0; the first cycle after rst falls SHALL show mem_req = 1.

Verification
REQ-036: Zero-wait ADDI (0010011) -> states 0,1,2,4,0; imm_sel = 0, alu_src_b = 1, a single reg_write and a single pc_write with pc_src = 0 in WB.
REQ-037: LW with mem_ready low for 3 cycles in MEM -> mem_req held for 4 cycles, then WB with wb_sel = 1; total 8 cycles.
REQ-038: BEQ with branch_taken = 1 -> pc_write with pc_src = 1 in EXEC and no reg_write; with branch_taken = 0 -> pc_src = 0.
REQ-039: Opcode 1111111 -> DECODE then TRAP; trap = 1 held with no strobes for 20 cycles; rst then returns to FETCH with trap = 0.
REQ-040: mem_ready held low in FETCH -> TRAP after exactly MEM_TIMEOUT wait cycles; mem_ready high on the timeout cycle -> DECODE instead.
REQ-041: rst asserted in MEM of a SW -> next cycle state = 0, mem_req = 0 during rst, and no pc_write is ever issued for that SW.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath and memory port.
// No latency of its own; it only groups the signals.
// Backpressure: mem_req is held until mem_ready. Every other strobe is a single-cycle pulse.
// Ports: opcode/branch_taken/mem_ready go into the controller. All remaining signals come out of it.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [2:0] imm_sel;
  logic       alu_src_b;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       trap;
  logic [2:0] state;

  // Controller side: it issues memory requests and datapath strobes.
  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
           alu_src_b, reg_write, wb_sel, trap, state
  );

  // Datapath / memory side.
  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
           alu_src_b, reg_write, wb_sel, trap, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Purpose: FSM controller for a multicycle RV32I datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Latency: branch 3, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5 cycles. Memory wait states add to this.
// Backpressure: waits in FETCH/MEM until mem_ready. Traps after MEM_TIMEOUT wait cycles.
// Ports: clk, rst (sync, active-high), bus (multicycle_control_if.master).
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // This is the count value at which one more wait cycle means the request has timed out.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t     r_state;
  logic [6:0] r_opc;
  logic [7:0] r_cnt;

  state_t     w_next;
  logic [6:0] w_opc;
  logic       w_legal;
  logic       w_timeout;
  logic [2:0] w_dec_imm;
  logic       w_dec_alub;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic [2:0] w_imm_sel;
  logic       w_alu_src_b;
  logic       w_reg_write;
  logic [1:0] w_wb_sel;

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 2'd0;
    w_imm_sel   = 3'd7;
    w_alu_src_b = 1'b0;
    w_reg_write = 1'b0;
    w_wb_sel    = 2'd0;
    w_legal     = 1'b1;
    w_dec_imm   = 3'd7;
    w_dec_alub  = 1'b1;
    w_timeout   = (r_cnt >= TMO_LAST);

    // The opcode is latched at the end of DECODE, so DECODE reads it directly from the IR.
    w_opc = (r_state == S_DECODE) ? bus.opcode : r_opc;

    case (w_opc)
      OP_R:                     begin w_dec_imm = 3'd7; w_dec_alub = 1'b0; end
      OP_IMM, OP_LOAD, OP_JALR: w_dec_imm = 3'd0;
      OP_STORE:                 w_dec_imm = 3'd1;
      OP_BRANCH:                begin w_dec_imm = 3'd2; w_dec_alub = 1'b0; end
      OP_LUI, OP_AUIPC:         w_dec_imm = 3'd3;
      OP_JAL:                   w_dec_imm = 3'd4;
      default:                  begin w_legal = 1'b0; w_dec_alub = 1'b0; end
    endcase

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        // mem_ready has priority over the timeout in the same cycle.
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_imm_sel   = w_dec_imm;
        w_alu_src_b = w_dec_alub;
        w_next      = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        w_imm_sel   = w_dec_imm;
        w_alu_src_b = w_dec_alub;
        case (r_opc)
          OP_BRANCH: begin
            w_pc_write = 1'b1;
            w_pc_src   = bus.branch_taken ? 2'd1 : 2'd0;
            w_next     = S_FETCH;
          end
          OP_LOAD, OP_STORE: w_next = S_MEM;
          default:           w_next = w_legal ? S_WB : S_TRAP;
        endcase
      end
      S_MEM: begin
        w_imm_sel   = w_dec_imm;
        w_alu_src_b = w_dec_alub;
        w_mem_req   = 1'b1;
        w_mem_we    = (r_opc == OP_STORE);
        if (bus.mem_ready) begin
          if (r_opc == OP_LOAD) begin
            w_next = S_WB;
          end else if (r_opc == OP_STORE) begin
            w_pc_write = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_TRAP;
          end
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        w_imm_sel   = w_dec_imm;
        w_alu_src_b = w_dec_alub;
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        case (r_opc)
          OP_LOAD:         w_wb_sel = 2'd1;
          OP_JAL, OP_JALR: w_wb_sel = 2'd2;
          OP_LUI:          w_wb_sel = 2'd3;
          default:         w_wb_sel = 2'd0;
        endcase
        case (r_opc)
          OP_JAL:  w_pc_src = 2'd1;
          OP_JALR: w_pc_src = 2'd2;
          default: w_pc_src = 2'd0;
        endcase
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase

    // While reset is held, the state register may still hold a pre-reset value. Keep the bus quiet.
    if (rst) begin
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_opc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opc <= bus.opcode;
      // The counter restarts on every state change, so it is fresh on entry to FETCH and MEM.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_mem_req && !bus.mem_ready && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.ir_write  = w_ir_write;
  assign bus.pc_write  = w_pc_write;
  assign bus.pc_src    = w_pc_src;
  assign bus.imm_sel   = w_imm_sel;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.reg_write = w_reg_write;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.trap      = (r_state == S_TRAP);
  assign bus.state     = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control with hand-computed per-cycle output vectors.
// Each cycle drives the inputs shortly after the rising edge and samples 2 ns later.
// Vector fields are {state, mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel, alu_src_b, reg_write, wb_sel, trap}.
module tb_multicycle_control;
  localparam int TMO = 10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] v(int st, int req, int we, int ir, int pcw, int pcs,
                                    int imm, int alub, int rw, int wbs, int trp);
    logic [2:0] s3, i3;
    logic [1:0] p2, w2;
    s3 = st[2:0];
    i3 = imm[2:0];
    p2 = pcs[1:0];
    w2 = wbs[1:0];
    return {s3, req[0], we[0], ir[0], pcw[0], p2, i3, alub[0], rw[0], w2, trp[0]};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.imm_sel, bus.alu_src_b, bus.reg_write, bus.wb_sel, bus.trap};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the output vector, then advance past the next edge.
  task automatic cyc(input string tag, input logic rdy, input logic br, input logic [16:0] exp);
    bus.mem_ready    = rdy;
    bus.branch_taken = br;
    #2;
    chk(tag, {15'd0, obs()}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [16:0] F_RDY, F_WAIT, TRAPV, RSTV;

  initial begin
    F_RDY  = v(0, 1, 0, 1, 0, 0, 7, 0, 0, 0, 0);
    F_WAIT = v(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    TRAPV  = v(5, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1);
    RSTV   = v(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);

    rst              = 1'b1;
    bus.opcode       = OP_IMM;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    @(posedge clk);
    #1;
    // Reset state. mem_ready is high here to show that it cannot produce ir_write.
    cyc("reset", 1'b1, 1'b0, RSTV);
    rst = 1'b0;

    // ADDI with zero wait states. The opcode is corrupted in EXEC to show it was latched.
    bus.opcode = OP_IMM;
    cyc("addi.F", 1'b1, 1'b0, F_RDY);
    cyc("addi.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.opcode = 7'h7F;
    cyc("addi.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("addi.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));

    // LW with 3 wait states in MEM. The total is 8 cycles.
    bus.opcode = OP_LOAD;
    cyc("lw.F", 1'b1, 1'b0, F_RDY);
    cyc("lw.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lw.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("lw.Mwait", 1'b0, 1'b0, v(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lw.Mrdy", 1'b1, 1'b0, v(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lw.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0));

    // BEQ, taken and not taken.
    bus.opcode = OP_BRANCH;
    cyc("beq1.F", 1'b1, 1'b0, F_RDY);
    cyc("beq1.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    cyc("beq1.E", 1'b0, 1'b1, v(2, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0));
    cyc("beq0.F", 1'b1, 1'b0, F_RDY);
    cyc("beq0.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    cyc("beq0.E", 1'b0, 1'b0, v(2, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));

    // SW with zero wait states.
    bus.opcode = OP_STORE;
    cyc("sw.F", 1'b1, 1'b0, F_RDY);
    cyc("sw.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("sw.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("sw.M", 1'b1, 1'b0, v(3, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0));

    // JAL, JALR, LUI, AUIPC write-back selects.
    bus.opcode = OP_JAL;
    cyc("jal.F", 1'b1, 1'b0, F_RDY);
    cyc("jal.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
    cyc("jal.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
    cyc("jal.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 1, 4, 1, 1, 2, 0));
    bus.opcode = OP_JALR;
    cyc("jalr.F", 1'b1, 1'b0, F_RDY);
    cyc("jalr.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("jalr.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("jalr.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 2, 0, 1, 1, 2, 0));
    bus.opcode = OP_LUI;
    cyc("lui.F", 1'b1, 1'b0, F_RDY);
    cyc("lui.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    cyc("lui.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    cyc("lui.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 0, 3, 1, 1, 3, 0));
    bus.opcode = OP_AUIPC;
    cyc("auipc.F", 1'b1, 1'b0, F_RDY);
    cyc("auipc.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    cyc("auipc.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    cyc("auipc.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 0, 3, 1, 1, 0, 0));

    // R-type with mem_ready held high throughout. It must be ignored outside FETCH/MEM.
    bus.opcode = OP_R;
    cyc("r.F", 1'b1, 1'b1, F_RDY);
    cyc("r.D", 1'b1, 1'b1, v(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    cyc("r.E", 1'b1, 1'b1, v(2, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    cyc("r.W", 1'b1, 1'b1, v(4, 0, 0, 0, 1, 0, 7, 0, 1, 0, 0));

    // mem_ready arrives on the timeout cycle and wins, so the FSM goes to DECODE.
    bus.opcode = OP_IMM;
    for (int i = 0; i < TMO - 1; i++) cyc("tmo.wait", 1'b0, 1'b0, F_WAIT);
    cyc("tmo.rdy_wins", 1'b1, 1'b0, F_RDY);
    cyc("tmo.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("tmo.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("tmo.W", 1'b0, 1'b0, v(4, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));

    // Exactly TMO wait cycles in FETCH lead to TRAP.
    for (int i = 0; i < TMO; i++) cyc("tmo.fwait", 1'b0, 1'b0, F_WAIT);
    cyc("tmo.trap", 1'b1, 1'b0, TRAPV);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("tmo.rst", 1'b0, 1'b0, RSTV);
    rst = 1'b0;

    // Illegal opcode leads to TRAP, which absorbs arbitrary inputs for 20 cycles until reset.
    bus.opcode = 7'b1111111;
    cyc("ill.F", 1'b1, 1'b0, F_RDY);
    cyc("ill.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 7'($urandom_range(0, 127));
      cyc("ill.trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TRAPV);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("ill.rst", 1'b0, 1'b0, RSTV);
    rst = 1'b0;
    cyc("ill.after_rst", 1'b0, 1'b0, F_WAIT);

    // Reset in the middle of a SW in MEM: the SW must never produce pc_write.
    bus.opcode = OP_STORE;
    cyc("swr.F", 1'b1, 1'b0, F_RDY);
    cyc("swr.D", 1'b0, 1'b0, v(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("swr.E", 1'b0, 1'b0, v(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("swr.M", 1'b0, 1'b0, v(3, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    #2;
    chk("swr.rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("swr.rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
    chk("swr.rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1;
    chk("swr.state_after_rst", {29'd0, bus.state}, 32'd0);
    chk("swr.pc_write_in_rst", {31'd0, bus.pc_write}, 32'd0);
    rst = 1'b0;
    cyc("swr.first_fetch", 1'b0, 1'b0, F_WAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
